// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, status codes and fetch FSM state type.
package y86_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned IMEM_W = 80;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ERR = 2'd2;
  localparam logic [1:0] S_BUB = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_split.sv
// Combinational instruction split: fields, constant word, validity, valP and
// the predicted next PC for one fetched instruction.
module fetch_split
  import y86_pkg::*;
(
  input  logic [XLEN-1:0]   pc,
  input  logic [IMEM_W-1:0] imem_data,
  input  logic              imem_error,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [XLEN-1:0]   val_c,
  output logic [XLEN-1:0]   val_p,
  output logic [XLEN-1:0]   pred_pc,
  output logic [1:0]        status
);

  logic [3:0] raw_icode;
  logic       need_regids;
  logic       need_valc;
  logic       invalid;

  assign raw_icode = imem_data[7:4];
  assign ifun      = imem_data[3:0];

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    invalid     = 1'b0;
    case (raw_icode)
      I_RRMOVQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      I_OPQ:  need_regids = 1'b1;
      I_JXX, I_CALL: need_valc = 1'b1;
      default: ;
    endcase
    // Function-code range depends on the instruction class.
    if (raw_icode > I_POPQ)                            invalid = 1'b1;
    else if (raw_icode == I_OPQ)                       invalid = (ifun > 4'd3);
    else if (raw_icode == I_JXX || raw_icode == I_RRMOVQ) invalid = (ifun > 4'd6);
    else                                               invalid = (ifun != 4'd0);
  end

  always_comb begin
    ra      = RNONE;
    rb      = RNONE;
    val_c   = '0;
    icode   = raw_icode;
    status  = S_AOK;
    if (need_regids) begin
      ra = imem_data[15:12];
      rb = imem_data[11:8];
    end
    if (need_valc) val_c = need_regids ? imem_data[79:16] : imem_data[71:8];
    val_p = pc + XLEN'(1) + XLEN'(need_regids) + (need_valc ? XLEN'(8) : XLEN'(0));
    pred_pc = (raw_icode == I_JXX || raw_icode == I_CALL) ? val_c : val_p;
    if (imem_error || invalid) begin
      status = S_ERR;
      icode  = I_NOP;
    end else if (raw_icode == I_HALT) begin
      status = S_HLT;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, predicted-PC register and RUN/HALT control
// that freezes fetch on halt/error until a mispredict or ret redirect.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              F_stall,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [XLEN-1:0]   M_valA,
  input  logic [3:0]        W_icode,
  input  logic [XLEN-1:0]   W_valM,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [IMEM_W-1:0] imem_data,
  input  logic              imem_error,
  output logic [XLEN-1:0]   f_pc,
  output logic [1:0]        f_status,
  output logic [3:0]        f_icode,
  output logic [3:0]        f_ifun,
  output logic [3:0]        f_rA,
  output logic [3:0]        f_rB,
  output logic [XLEN-1:0]   f_valC,
  output logic [XLEN-1:0]   f_valP,
  output logic [XLEN-1:0]   F_predPC,
  output logic              f_halted
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pred_next;
  logic            mispredict, ret_sel, redirect;

  logic [3:0]      s_icode, s_ifun, s_ra, s_rb;
  logic [XLEN-1:0] s_valc, s_valp, s_pred;
  logic [1:0]      s_status;

  assign mispredict = (M_icode == I_JXX) && !M_Cnd;
  assign ret_sel    = (W_icode == I_RET);
  assign redirect   = mispredict || ret_sel;

  always_comb begin
    if (mispredict)   f_pc = M_valA;
    else if (ret_sel) f_pc = W_valM;
    else              f_pc = F_predPC;
  end

  assign imem_addr = f_pc;
  assign f_halted  = (state == ST_HALT);

  fetch_split u_split (
    .pc         (f_pc),
    .imem_data  (imem_data),
    .imem_error (imem_error),
    .icode      (s_icode),
    .ifun       (s_ifun),
    .ra         (s_ra),
    .rb         (s_rb),
    .val_c      (s_valc),
    .val_p      (s_valp),
    .pred_pc    (s_pred),
    .status     (s_status)
  );

  // Present a bubble to the F->D register while reset is held.
  always_comb begin
    f_icode  = s_icode;
    f_ifun   = s_ifun;
    f_rA     = s_ra;
    f_rB     = s_rb;
    f_valC   = s_valc;
    f_valP   = s_valp;
    f_status = s_status;
    if (!rst_n) begin
      f_icode  = I_NOP;
      f_ifun   = 4'h0;
      f_rA     = RNONE;
      f_rB     = RNONE;
      f_valC   = '0;
      f_valP   = '0;
      f_status = S_BUB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      F_predPC <= RESET_PC;
    end else begin
      state    <= state_next;
      F_predPC <= pred_next;
    end
  end

  // Entering or staying in HALT parks the PC on the faulting instruction.
  always_comb begin
    state_next = state;
    pred_next  = F_predPC;
    case (state)
      ST_RUN: begin
        if (!F_stall) begin
          if (s_status != S_AOK) begin
            state_next = ST_HALT;
            pred_next  = f_pc;
          end else begin
            pred_next  = s_pred;
          end
        end
      end
      ST_HALT: begin
        if (!F_stall && redirect) begin
          if (s_status != S_AOK) begin
            pred_next  = f_pc;
          end else begin
            state_next = ST_RUN;
            pred_next  = s_pred;
          end
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

endmodule
